// File: rtl/array_responder.sv
// Synchronous memory responder for the Array interface, with a programmable
// response latency and a lower-priority host port for preload and inspection.
module array_responder #(
  parameter int INT_W   = 8,
  parameter int ADDR_W  = 8,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [INT_W-1:0]  di,
  // `do` is a reserved word, so the response data port is named dout.
  output logic [INT_W-1:0]  dout,
  input  logic              valid,
  output logic              ready,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic              host_we,
  input  logic [INT_W-1:0]  host_di,
  output logic [INT_W-1:0]  host_do,
  input  logic              host_valid,
  output logic              host_ready
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_CNT = 4'(LATENCY - 1);

  generate
    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
      $error("array_responder: LATENCY must be within 1..15");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic [INT_W-1:0]  resp_q;
  logic [INT_W-1:0]  mem [DEPTH];

  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  host_idx;
  logic              init_acc;
  logic              host_acc;
  logic [INT_W-1:0]  acc_data;
  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [INT_W-1:0]  wr_data;

  // Addresses wrap: only the low index bits select a word.
  assign idx      = addr[IDX_W-1:0];
  assign host_idx = host_addr[IDX_W-1:0];

  // The initiator always wins; the host is also held off during its own
  // completion pulse so host_ready never stays high two cycles in a row.
  assign init_acc = (state == IDLE) && valid;
  assign host_acc = (state == IDLE) && !valid && host_valid && !host_ready;

  // Writes echo the written value; reads see memory as it was before the edge.
  assign acc_data = we ? di : mem[idx];

  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = host_idx;
    wr_data = host_di;
    if (init_acc && we) begin
      wr_en   = 1'b1;
      wr_idx  = idx;
      wr_data = di;
    end else if (host_acc && host_we) begin
      wr_en = 1'b1;
    end
  end

  // Memory is never cleared; reset only suppresses writes on its own edge.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      ready      <= 1'b0;
      dout       <= '0;
      host_ready <= 1'b0;
      host_do    <= '0;
    end else begin
      host_ready <= host_acc;
      if (host_acc && !host_we) begin
        host_do <= mem[host_idx];
      end

      case (state)
        IDLE: begin
          if (valid) begin
            resp_q <= acc_data;
            if (LATENCY == 1) begin
              state <= RESP;
              ready <= 1'b1;
              dout  <= acc_data;
            end else begin
              state <= WAIT;
              cnt   <= WAIT_CNT;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd1) begin
            state <= RESP;
            ready <= 1'b1;
            dout  <= resp_q;
            cnt   <= '0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          // Completion and abandonment both return to IDLE; dout is held.
          state <= IDLE;
          ready <= 1'b0;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_array_responder.sv
// Self-checking bench for array_responder: three instances with different
// latency/depth settings, directed scenarios plus randomized traffic.
module tb_array_responder;

  logic       clk;
  logic       rst;
  logic [7:0] addr_s      [3];
  logic       we_s        [3];
  logic [7:0] di_s        [3];
  logic [7:0] dout_s      [3];
  logic       valid_s     [3];
  logic       ready_s     [3];
  logic [7:0] host_addr_s [3];
  logic       host_we_s   [3];
  logic [7:0] host_di_s   [3];
  logic [7:0] host_do_s   [3];
  logic       host_valid_s[3];
  logic       host_ready_s[3];

  logic [7:0] mem_m [3][256];
  bit         known [3][256];

  int n_cmp;
  int n_fail;

  array_responder #(.INT_W(8), .ADDR_W(8), .DEPTH(256), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .addr(addr_s[0]), .we(we_s[0]), .di(di_s[0]),
    .dout(dout_s[0]), .valid(valid_s[0]), .ready(ready_s[0]),
    .host_addr(host_addr_s[0]), .host_we(host_we_s[0]), .host_di(host_di_s[0]),
    .host_do(host_do_s[0]), .host_valid(host_valid_s[0]), .host_ready(host_ready_s[0]));

  array_responder #(.INT_W(8), .ADDR_W(8), .DEPTH(16), .LATENCY(4)) u_l4 (
    .clk(clk), .rst(rst), .addr(addr_s[1]), .we(we_s[1]), .di(di_s[1]),
    .dout(dout_s[1]), .valid(valid_s[1]), .ready(ready_s[1]),
    .host_addr(host_addr_s[1]), .host_we(host_we_s[1]), .host_di(host_di_s[1]),
    .host_do(host_do_s[1]), .host_valid(host_valid_s[1]), .host_ready(host_ready_s[1]));

  array_responder #(.INT_W(8), .ADDR_W(8), .DEPTH(256), .LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst), .addr(addr_s[2]), .we(we_s[2]), .di(di_s[2]),
    .dout(dout_s[2]), .valid(valid_s[2]), .ready(ready_s[2]),
    .host_addr(host_addr_s[2]), .host_we(host_we_s[2]), .host_di(host_di_s[2]),
    .host_do(host_do_s[2]), .host_valid(host_valid_s[2]), .host_ready(host_ready_s[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int lat_of(input int u);
    return (u == 0) ? 1 : ((u == 1) ? 4 : 3);
  endfunction

  function automatic int idx_of(input int u, input logic [7:0] a);
    return (u == 1) ? int'(a) % 16 : int'(a);
  endfunction

  task automatic model_write(input int u, input logic [7:0] a, input logic [7:0] d);
    mem_m[u][idx_of(u, a)] = d;
    known[u][idx_of(u, a)] = 1'b1;
  endtask

  // Full initiator transaction; request fields are scrambled while waiting.
  task automatic txn(input int u, input logic w, input logic [7:0] a,
                     input logic [7:0] d, output logic [7:0] obs, output int n);
    valid_s[u] = 1'b1;
    we_s[u]    = w;
    addr_s[u]  = a;
    di_s[u]    = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!ready_s[u]) begin
        addr_s[u] = 8'($urandom);
        di_s[u]   = 8'($urandom);
        we_s[u]   = 1'($urandom);
      end
    end while (!ready_s[u] && n < 40);
    obs = dout_s[u];
    @(negedge clk);
    valid_s[u] = 1'b0;
  endtask

  task automatic host_op(input int u, input logic w, input logic [7:0] a,
                         input logic [7:0] d, output logic [7:0] obs, output int n);
    @(negedge clk);
    host_valid_s[u] = 1'b1;
    host_we_s[u]    = w;
    host_addr_s[u]  = a;
    host_di_s[u]    = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!host_ready_s[u] && n < 40);
    host_valid_s[u] = 1'b0;
    obs = host_do_s[u];
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      n_cmp++; if (ready_s[u] !== 1'b0) begin n_fail++; $display("FAIL reset_ready[%0d]: got %b want 0", u, ready_s[u]); end
      n_cmp++; if (dout_s[u] !== 8'd0) begin n_fail++; $display("FAIL reset_do[%0d]: got %0d want 0", u, dout_s[u]); end
      n_cmp++; if (host_ready_s[u] !== 1'b0) begin n_fail++; $display("FAIL reset_host_ready[%0d]: got %b want 0", u, host_ready_s[u]); end
      n_cmp++; if (host_do_s[u] !== 8'd0) begin n_fail++; $display("FAIL reset_host_do[%0d]: got %0d want 0", u, host_do_s[u]); end
    end
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    logic [7:0] obs;
    int n;
    txn(0, 1'b1, 8'd3, 8'd42, obs, n);
    model_write(0, 8'd3, 8'd42);
    n_cmp++; if (n !== 1) begin n_fail++; $display("FAIL wr_latency: got %0d want 1", n); end
    n_cmp++; if (obs !== 8'd42) begin n_fail++; $display("FAIL wr_echo: got %0d want 42", obs); end
    n_cmp++; if (ready_s[0] !== 1'b0) begin n_fail++; $display("FAIL wr_ready_low: got %b want 0", ready_s[0]); end
    txn(0, 1'b0, 8'd3, 8'd0, obs, n);
    n_cmp++; if (n !== 1) begin n_fail++; $display("FAIL rd_latency: got %0d want 1", n); end
    n_cmp++; if (obs !== 8'd42) begin n_fail++; $display("FAIL rd_data: got %0d want 42", obs); end
  endtask

  task automatic test_latency4();
    logic [7:0] obs;
    int n;
    host_op(1, 1'b1, 8'd7, 8'd99, obs, n);
    model_write(1, 8'd7, 8'd99);
    n_cmp++; if (n !== 1) begin n_fail++; $display("FAIL lat4_host_wait: got %0d want 1", n); end
    txn(1, 1'b0, 8'd7, 8'd0, obs, n);
    n_cmp++; if (n !== 4) begin n_fail++; $display("FAIL lat4_latency: got %0d want 4", n); end
    n_cmp++; if (obs !== 8'd99) begin n_fail++; $display("FAIL lat4_data: got %0d want 99", obs); end
  endtask

  task automatic test_arbitration();
    logic [7:0] obs;
    int n;
    host_op(0, 1'b1, 8'd5, 8'd8, obs, n);
    model_write(0, 8'd5, 8'd8);
    valid_s[0] = 1'b1; we_s[0] = 1'b0; addr_s[0] = 8'd5; di_s[0] = 8'd0;
    host_valid_s[0] = 1'b1; host_we_s[0] = 1'b1; host_addr_s[0] = 8'd5; host_di_s[0] = 8'd17;
    @(negedge clk);
    n_cmp++; if (ready_s[0] !== 1'b1) begin n_fail++; $display("FAIL arb_ready: got %b want 1", ready_s[0]); end
    n_cmp++; if (dout_s[0] !== 8'd8) begin n_fail++; $display("FAIL arb_data: got %0d want 8", dout_s[0]); end
    n_cmp++; if (host_ready_s[0] !== 1'b0) begin n_fail++; $display("FAIL arb_host_early: got %b want 0", host_ready_s[0]); end
    @(negedge clk);
    valid_s[0] = 1'b0;
    n_cmp++; if (host_ready_s[0] !== 1'b0) begin n_fail++; $display("FAIL arb_host_in_resp: got %b want 0", host_ready_s[0]); end
    @(negedge clk);
    n_cmp++; if (host_ready_s[0] !== 1'b1) begin n_fail++; $display("FAIL arb_host_accept: got %b want 1", host_ready_s[0]); end
    host_valid_s[0] = 1'b0;
    model_write(0, 8'd5, 8'd17);
    txn(0, 1'b0, 8'd5, 8'd0, obs, n);
    n_cmp++; if (obs !== 8'd17) begin n_fail++; $display("FAIL arb_readback: got %0d want 17", obs); end
  endtask

  task automatic test_abandon();
    logic [7:0] obs;
    int n;
    valid_s[2] = 1'b1; we_s[2] = 1'b1; addr_s[2] = 8'd10; di_s[2] = 8'd55;
    model_write(2, 8'd10, 8'd55);
    @(negedge clk);
    valid_s[2] = 1'b0;
    n_cmp++; if (ready_s[2] !== 1'b0) begin n_fail++; $display("FAIL ab_ready_c1: got %b want 0", ready_s[2]); end
    @(negedge clk);
    n_cmp++; if (ready_s[2] !== 1'b0) begin n_fail++; $display("FAIL ab_ready_c2: got %b want 0", ready_s[2]); end
    @(negedge clk);
    n_cmp++; if (ready_s[2] !== 1'b1) begin n_fail++; $display("FAIL ab_ready_c3: got %b want 1", ready_s[2]); end
    n_cmp++; if (dout_s[2] !== 8'd55) begin n_fail++; $display("FAIL ab_echo: got %0d want 55", dout_s[2]); end
    @(negedge clk);
    n_cmp++; if (ready_s[2] !== 1'b0) begin n_fail++; $display("FAIL ab_ready_c4: got %b want 0", ready_s[2]); end
    host_op(2, 1'b0, 8'd10, 8'd0, obs, n);
    n_cmp++; if (n !== 1) begin n_fail++; $display("FAIL ab_idle: host wait %0d want 1", n); end
    n_cmp++; if (obs !== 8'd55) begin n_fail++; $display("FAIL ab_host_read: got %0d want 55", obs); end
  endtask

  task automatic test_wrap();
    logic [7:0] obs;
    int n;
    txn(1, 1'b1, 8'h13, 8'd6, obs, n);
    model_write(1, 8'h13, 8'd6);
    txn(1, 1'b0, 8'h03, 8'd0, obs, n);
    n_cmp++; if (obs !== 8'd6) begin n_fail++; $display("FAIL wrap_data: got %0d want 6", obs); end
  endtask

  task automatic test_reset_wait();
    logic [7:0] obs;
    int n;
    txn(1, 1'b1, 8'h20, 8'd77, obs, n);
    model_write(1, 8'h20, 8'd77);
    valid_s[1] = 1'b1; we_s[1] = 1'b0; addr_s[1] = 8'h20;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    valid_s[1] = 1'b0;
    @(negedge clk);
    n_cmp++; if (ready_s[1] !== 1'b0) begin n_fail++; $display("FAIL rstw_ready: got %b want 0", ready_s[1]); end
    n_cmp++; if (host_ready_s[1] !== 1'b0) begin n_fail++; $display("FAIL rstw_host_ready: got %b want 0", host_ready_s[1]); end
    n_cmp++; if (dout_s[1] !== 8'd0) begin n_fail++; $display("FAIL rstw_do: got %0d want 0", dout_s[1]); end
    rst = 1'b0;
    txn(1, 1'b0, 8'h20, 8'd0, obs, n);
    n_cmp++; if (n !== 4) begin n_fail++; $display("FAIL rstw_latency: got %0d want 4", n); end
    n_cmp++; if (obs !== 8'd77) begin n_fail++; $display("FAIL rstw_data: got %0d want 77", obs); end
  endtask

  task automatic test_host_pulse();
    logic [7:0] pat;
    @(negedge clk);
    host_valid_s[2] = 1'b1; host_we_s[2] = 1'b0; host_addr_s[2] = 8'd10;
    pat = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      pat[i] = host_ready_s[2];
    end
    host_valid_s[2] = 1'b0;
    n_cmp++; if (pat !== 8'b0101_0101) begin n_fail++; $display("FAIL host_pulse: got %b want 01010101", pat); end
    n_cmp++; if (host_do_s[2] !== mem_m[2][10]) begin n_fail++; $display("FAIL host_pulse_data: got %0d want %0d", host_do_s[2], mem_m[2][10]); end
  endtask

  task automatic test_random();
    logic [7:0] obs;
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] exp;
    bit         chk;
    int n;
    int r;
    for (int u = 0; u < 3; u++) begin
      for (int k = 0; k < 50; k++) begin
        r = $urandom_range(0, 3);
        a = (u == 1) ? 8'($urandom) : 8'($urandom_range(0, 31));
        d = 8'($urandom);
        chk = known[u][idx_of(u, a)];
        exp = mem_m[u][idx_of(u, a)];
        case (r)
          0: begin
            txn(u, 1'b1, a, d, obs, n);
            model_write(u, a, d);
            n_cmp++; if (n !== lat_of(u) || obs !== d) begin n_fail++; $display("FAIL rnd_write[%0d]: lat %0d data %0d want lat %0d data %0d", u, n, obs, lat_of(u), d); end
          end
          1: begin
            txn(u, 1'b0, a, d, obs, n);
            n_cmp++; if (n !== lat_of(u)) begin n_fail++; $display("FAIL rnd_read_lat[%0d]: got %0d want %0d", u, n, lat_of(u)); end
            if (chk) begin
              n_cmp++; if (obs !== exp) begin n_fail++; $display("FAIL rnd_read[%0d] addr %0d: got %0d want %0d", u, a, obs, exp); end
            end
          end
          2: begin
            host_op(u, 1'b1, a, d, obs, n);
            model_write(u, a, d);
            n_cmp++; if (n !== 1) begin n_fail++; $display("FAIL rnd_hwrite[%0d]: wait %0d want 1", u, n); end
          end
          default: begin
            host_op(u, 1'b0, a, d, obs, n);
            n_cmp++; if (n !== 1) begin n_fail++; $display("FAIL rnd_hread_wait[%0d]: got %0d want 1", u, n); end
            if (chk) begin
              n_cmp++; if (obs !== exp) begin n_fail++; $display("FAIL rnd_hread[%0d] addr %0d: got %0d want %0d", u, a, obs, exp); end
            end
          end
        endcase
        n_cmp++; if (ready_s[u] !== 1'b0) begin n_fail++; $display("FAIL rnd_ready_idle[%0d]: got %b want 0", u, ready_s[u]); end
      end
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst    = 1'b1;
    for (int u = 0; u < 3; u++) begin
      addr_s[u] = '0; we_s[u] = 1'b0; di_s[u] = '0; valid_s[u] = 1'b0;
      host_addr_s[u] = '0; host_we_s[u] = 1'b0; host_di_s[u] = '0; host_valid_s[u] = 1'b0;
      for (int i = 0; i < 256; i++) begin
        mem_m[u][i] = '0;
        known[u][i] = 1'b0;
      end
    end
    test_reset();
    test_write_read();
    test_latency4();
    test_arbitration();
    test_abandon();
    test_wrap();
    test_reset_wait();
    test_host_pulse();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
